// File: rtl/processor_pkg.sv
// rtl/processor_pkg.sv - shared widths, opcodes, register indices and state/ALU enums
package processor_pkg;

  localparam int DEF_REG_WIDTH           = 12;
  localparam int DEF_INS_WIDTH           = 8;
  localparam int DEF_INS_MEM_ADDR_WIDTH  = 8;
  localparam int DEF_DATA_MEM_ADDR_WIDTH = 12;

  localparam logic [7:0] OP_NOP   = 8'h00;
  localparam logic [7:0] OP_END   = 8'h01;
  localparam logic [7:0] OP_CLAC  = 8'h02;
  localparam logic [7:0] OP_LDAC  = 8'h03;
  localparam logic [7:0] OP_STAC  = 8'h04;
  localparam logic [7:0] OP_INCAC = 8'h05;
  localparam logic [7:0] OP_DECAC = 8'h06;
  localparam logic [7:0] OP_LDIAC = 8'h70;
  localparam logic [7:0] OP_JMPZ  = 8'h80;
  localparam logic [7:0] OP_JMPNZ = 8'h81;
  localparam logic [7:0] OP_JMP   = 8'h82;

  // Upper nibble of the register-operand instruction family 0xHr
  localparam logic [3:0] HI_MVACR = 4'h1;
  localparam logic [3:0] HI_MVRAC = 4'h2;
  localparam logic [3:0] HI_ADD   = 4'h3;
  localparam logic [3:0] HI_SUB   = 4'h4;
  localparam logic [3:0] HI_MUL   = 4'h5;
  localparam logic [3:0] HI_INCR  = 4'h6;

  localparam logic [2:0] RI_AR = 3'd0;
  localparam logic [2:0] RI_R  = 3'd1;
  localparam logic [2:0] RI_R1 = 3'd2;
  localparam logic [2:0] RI_R2 = 3'd3;
  localparam logic [2:0] RI_R3 = 3'd4;
  localparam logic [2:0] RI_R4 = 3'd5;
  localparam logic [2:0] RI_R5 = 3'd6;
  localparam logic [2:0] RI_TR = 3'd7;
  localparam int         NUM_REGS = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOADIR,
    S_EXEC,
    S_LDWAIT,
    S_OPWAIT,
    S_DONE
  } state_t;

  typedef enum logic [2:0] {
    ALU_PASS,
    ALU_CLR,
    ALU_INC,
    ALU_DEC,
    ALU_ADD,
    ALU_SUB,
    ALU_MUL
  } alu_op_t;

endpackage

// File: rtl/processor_alu.sv
// rtl/processor_alu.sv - combinational accumulator ALU: result = AC op B, plus zero flag
module processor_alu
  import processor_pkg::*;
#(
  parameter int REG_WIDTH = DEF_REG_WIDTH
) (
  input  alu_op_t              i_op,
  input  logic [REG_WIDTH-1:0] i_ac,
  input  logic [REG_WIDTH-1:0] i_b,
  output logic [REG_WIDTH-1:0] o_result,
  output logic                 o_zero
);

  // All results are taken in REG_WIDTH context, so every op wraps modulo 2^REG_WIDTH
  always_comb begin
    o_result = i_b;
    case (i_op)
      ALU_PASS: o_result = i_b;
      ALU_CLR:  o_result = '0;
      ALU_INC:  o_result = i_ac + REG_WIDTH'(1);
      ALU_DEC:  o_result = i_ac - REG_WIDTH'(1);
      ALU_ADD:  o_result = i_ac + i_b;
      ALU_SUB:  o_result = i_ac - i_b;
      ALU_MUL:  o_result = i_ac * i_b;
      default:  o_result = i_b;
    endcase
    o_zero = (o_result == '0);
  end

endmodule

// File: rtl/processor.sv
// rtl/processor.sv - multi-cycle 12-bit accumulator processor core with external ins/data memories
module processor
  import processor_pkg::*;
#(
  parameter int REG_WIDTH           = DEF_REG_WIDTH,
  parameter int INS_WIDTH           = DEF_INS_WIDTH,
  parameter int INS_MEM_ADDR_WIDTH  = DEF_INS_MEM_ADDR_WIDTH,
  parameter int DATA_MEM_ADDR_WIDTH = DEF_DATA_MEM_ADDR_WIDTH
) (
  input  logic                           clk,
  input  logic                           rstN,
  input  logic                           startN,
  input  logic [REG_WIDTH-1:0]           ProcessorDataIn,
  input  logic [INS_WIDTH-1:0]           InsMemOut,
  output logic [REG_WIDTH-1:0]           ProcessorDataOut,
  output logic [DATA_MEM_ADDR_WIDTH-1:0] dataMemAddr,
  output logic [INS_MEM_ADDR_WIDTH-1:0]  insMemAddr,
  output logic                           DataMemWrEn,
  output logic                           done,
  output logic                           ready
);

  state_t                        r_state;
  state_t                        w_state_nxt;
  logic [REG_WIDTH-1:0]          r_ac;
  logic [REG_WIDTH-1:0]          r_regs [NUM_REGS];
  logic [INS_MEM_ADDR_WIDTH-1:0] r_pc;
  logic [INS_WIDTH-1:0]          r_ir;
  logic                          r_z;

  logic [3:0]                    w_hi;
  logic [2:0]                    w_ri;
  logic [REG_WIDTH-1:0]          w_rv;
  logic [REG_WIDTH-1:0]          w_operand;
  logic [INS_MEM_ADDR_WIDTH-1:0] w_pc_inc;
  logic [INS_MEM_ADDR_WIDTH-1:0] w_pc_nxt;
  alu_op_t                       w_alu_op;
  logic [REG_WIDTH-1:0]          w_alu_b;
  logic [REG_WIDTH-1:0]          w_alu_res;
  logic                          w_alu_z;
  logic                          w_ac_we;
  logic                          w_z_we;
  logic                          w_reg_we;
  logic [REG_WIDTH-1:0]          w_reg_wdata;
  logic                          w_ir_we;
  logic                          w_wr_en;

  assign w_hi      = r_ir[7:4];
  assign w_ri      = r_ir[2:0];
  assign w_rv      = r_regs[w_ri];
  assign w_operand = {{(REG_WIDTH-INS_WIDTH){1'b0}}, InsMemOut};
  assign w_pc_inc  = r_pc + INS_MEM_ADDR_WIDTH'(1);

  processor_alu #(
    .REG_WIDTH (REG_WIDTH)
  ) u_alu (
    .i_op     (w_alu_op),
    .i_ac     (r_ac),
    .i_b      (w_alu_b),
    .o_result (w_alu_res),
    .o_zero   (w_alu_z)
  );

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_alu_op    = ALU_PASS;
    w_alu_b     = w_rv;
    w_ac_we     = 1'b0;
    w_z_we      = 1'b0;
    w_reg_we    = 1'b0;
    w_reg_wdata = r_ac;
    w_ir_we     = 1'b0;
    w_wr_en     = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (!startN) begin
          w_pc_nxt    = '0;
          w_state_nxt = S_FETCH;
        end
      end
      S_FETCH: w_state_nxt = S_LOADIR;
      S_LOADIR: begin
        w_ir_we     = 1'b1;
        w_pc_nxt    = w_pc_inc;
        w_state_nxt = S_EXEC;
      end
      S_EXEC: begin
        w_state_nxt = S_FETCH;
        case (r_ir)
          OP_END:   w_state_nxt = S_DONE;
          OP_CLAC:  begin w_alu_op = ALU_CLR; w_ac_we = 1'b1; w_z_we = 1'b1; end
          OP_LDAC:  w_state_nxt = S_LDWAIT;
          OP_STAC:  w_wr_en = 1'b1;
          OP_INCAC: begin w_alu_op = ALU_INC; w_ac_we = 1'b1; w_z_we = 1'b1; end
          OP_DECAC: begin w_alu_op = ALU_DEC; w_ac_we = 1'b1; w_z_we = 1'b1; end
          OP_LDIAC, OP_JMPZ, OP_JMPNZ, OP_JMP: w_state_nxt = S_OPWAIT;
          default: begin
            // Register-operand family; IR[3] set or other nibbles fall through as NOP
            if (!r_ir[3]) begin
              case (w_hi)
                HI_MVACR: w_reg_we = 1'b1;
                HI_MVRAC: begin w_alu_op = ALU_PASS; w_ac_we = 1'b1; end
                HI_ADD:   begin w_alu_op = ALU_ADD; w_ac_we = 1'b1; w_z_we = 1'b1; end
                HI_SUB:   begin w_alu_op = ALU_SUB; w_ac_we = 1'b1; w_z_we = 1'b1; end
                HI_MUL:   begin w_alu_op = ALU_MUL; w_ac_we = 1'b1; w_z_we = 1'b1; end
                HI_INCR: begin
                  w_reg_we    = 1'b1;
                  w_reg_wdata = w_rv + REG_WIDTH'(1);
                end
                default: ;
              endcase
            end
          end
        endcase
      end
      S_LDWAIT: begin
        w_alu_b     = ProcessorDataIn;
        w_ac_we     = 1'b1;
        w_z_we      = 1'b1;
        w_state_nxt = S_FETCH;
      end
      S_OPWAIT: begin
        w_state_nxt = S_FETCH;
        w_pc_nxt    = w_pc_inc;
        case (r_ir)
          OP_LDIAC: begin w_alu_b = w_operand; w_ac_we = 1'b1; w_z_we = 1'b1; end
          OP_JMP:   w_pc_nxt = InsMemOut[INS_MEM_ADDR_WIDTH-1:0];
          OP_JMPZ:  if (r_z) w_pc_nxt = InsMemOut[INS_MEM_ADDR_WIDTH-1:0];
          OP_JMPNZ: if (!r_z) w_pc_nxt = InsMemOut[INS_MEM_ADDR_WIDTH-1:0];
          default: ;
        endcase
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_ac <= '0;
      r_pc <= '0;
      r_ir <= '0;
      r_z  <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      r_pc <= w_pc_nxt;
      if (w_ir_we)  r_ir <= InsMemOut;
      if (w_ac_we)  r_ac <= w_alu_res;
      if (w_z_we)   r_z <= w_alu_z;
      if (w_reg_we) r_regs[w_ri] <= w_reg_wdata;
    end
  end

  assign ProcessorDataOut = r_ac;
  assign dataMemAddr      = r_regs[RI_AR][DATA_MEM_ADDR_WIDTH-1:0];
  assign insMemAddr       = r_pc;
  assign DataMemWrEn      = w_wr_en;
  assign done             = (r_state == S_DONE);
  assign ready            = (r_state == S_IDLE);

endmodule

// File: tb/tb_processor.sv
// tb/tb_processor.sv - directed and random programs checked against an ISA-level model
module tb_processor;

  logic        clk = 1'b0;
  logic        rstN;
  logic        startN;
  logic [11:0] ProcessorDataIn;
  logic [7:0]  InsMemOut;
  logic [11:0] ProcessorDataOut;
  logic [11:0] dataMemAddr;
  logic [7:0]  insMemAddr;
  logic        DataMemWrEn;
  logic        done;
  logic        ready;

  processor dut (
    .clk              (clk),
    .rstN             (rstN),
    .startN           (startN),
    .ProcessorDataIn  (ProcessorDataIn),
    .InsMemOut        (InsMemOut),
    .ProcessorDataOut (ProcessorDataOut),
    .dataMemAddr      (dataMemAddr),
    .insMemAddr       (insMemAddr),
    .DataMemWrEn      (DataMemWrEn),
    .done             (done),
    .ready            (ready)
  );

  always #5 clk = ~clk;

  logic [7:0]  ins_mem  [256];
  logic [11:0] data_mem [4096];
  int          wr_cnt = 0;
  logic [11:0] last_wr_addr;
  logic [11:0] last_wr_data;

  always @(posedge clk) begin
    InsMemOut       <= ins_mem[insMemAddr];
    ProcessorDataIn <= data_mem[dataMemAddr];
  end

  // Write strobe is held through the whole STAC cycle, so capturing mid-cycle is safe
  always @(negedge clk) begin
    if (DataMemWrEn) begin
      data_mem[dataMemAddr] = ProcessorDataOut;
      wr_cnt       = wr_cnt + 1;
      last_wr_addr = dataMemAddr;
      last_wr_data = ProcessorDataOut;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ISA-level reference state
  logic [11:0] m_ac;
  logic [11:0] m_reg [8];
  logic        m_z;
  logic [11:0] m_mem [4096];
  int          m_cycles;
  int          m_writes;

  function automatic logic [11:0] w12(input int x);
    return x[11:0];
  endfunction

  task automatic model_reset();
    m_ac = '0;
    m_z  = 1'b0;
    for (int i = 0; i < 8; i++) m_reg[i] = '0;
  endtask

  task automatic model_run();
    logic [7:0] pc;
    logic [7:0] ir;
    logic [7:0] opnd;
    int         v;
    bit         fin;
    pc = 0; fin = 0; m_cycles = 0; m_writes = 0;
    for (int steps = 0; steps < 2000 && !fin; steps++) begin
      ir = ins_mem[pc];
      pc = pc + 8'd1;
      m_cycles += 3;
      if (ir == 8'h70 || ir == 8'h80 || ir == 8'h81 || ir == 8'h82) begin
        opnd = ins_mem[pc];
        m_cycles += 1;
        if (ir == 8'h70) begin
          m_ac = {4'h0, opnd};
          m_z  = (m_ac == 0);
          pc   = pc + 8'd1;
        end else if (ir == 8'h82 || (ir == 8'h80 && m_z) || (ir == 8'h81 && !m_z)) begin
          pc = opnd;
        end else begin
          pc = pc + 8'd1;
        end
      end else if (ir == 8'h01) begin
        fin = 1;
      end else if (ir >= 8'h02 && ir <= 8'h06) begin
        case (ir)
          8'h02: begin m_ac = 0; m_z = 1; end
          8'h03: begin m_ac = m_mem[m_reg[0]]; m_z = (m_ac == 0); m_cycles += 1; end
          8'h04: begin m_mem[m_reg[0]] = m_ac; m_writes++; end
          8'h05: begin m_ac = w12(int'(m_ac) + 1); m_z = (m_ac == 0); end
          default: begin m_ac = w12(int'(m_ac) - 1); m_z = (m_ac == 0); end
        endcase
      end else if (ir[7:4] >= 4'd1 && ir[7:4] <= 4'd6 && !ir[3]) begin
        v = int'(m_reg[ir[2:0]]);
        case (ir[7:4])
          4'd1: m_reg[ir[2:0]] = m_ac;
          4'd2: m_ac = m_reg[ir[2:0]];
          4'd3: begin m_ac = w12(int'(m_ac) + v); m_z = (m_ac == 0); end
          4'd4: begin m_ac = w12(int'(m_ac) - v); m_z = (m_ac == 0); end
          4'd5: begin m_ac = w12(int'(m_ac) * v); m_z = (m_ac == 0); end
          default: m_reg[ir[2:0]] = w12(v + 1);
        endcase
      end
    end
  endtask

  task automatic load_prog(input logic [255:0] bytes, input int n);
    for (int i = 0; i < 256; i++) ins_mem[i] = 8'h01;
    for (int i = 0; i < n; i++) ins_mem[i] = bytes[8*(n-1-i) +: 8];
  endtask

  task automatic prep_mem();
    for (int i = 0; i < 4096; i++) begin
      data_mem[i] = ($urandom_range(0, 7) == 0) ? 12'h000 : 12'($urandom);
      m_mem[i]    = data_mem[i];
    end
  endtask

  task automatic exec_and_compare(output int cyc);
    int base;
    int diffs;
    model_run();
    base = wr_cnt;
    @(negedge clk); startN = 1'b0;
    @(negedge clk); startN = 1'b1;
    check_eq("busy_ready", ready, 1'b0);
    cyc = 0;
    while (!done && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("done_reached", done, 1'b1);
    check_eq("cycles", cyc, m_cycles);
    check_eq("ac", ProcessorDataOut, m_ac);
    check_eq("ar", dataMemAddr, m_reg[0]);
    check_eq("writes", wr_cnt - base, m_writes);
    diffs = 0;
    for (int i = 0; i < 4096; i++) if (data_mem[i] !== m_mem[i]) diffs++;
    check_eq("mem_diffs", diffs, 0);
  endtask

  task automatic gen_random();
    logic [7:0] op [30];
    logic [7:0] opnd [30];
    int         len [30];
    int         addr [31];
    int         n;
    int         pick;
    n = $urandom_range(4, 30);
    for (int i = 0; i < n; i++) begin
      pick = $urandom_range(0, 9);
      len[i]  = 1;
      opnd[i] = 8'($urandom);
      if (pick <= 1) begin
        op[i] = 8'($urandom);
        if (op[i] == 8'h01 || op[i] == 8'h70 || (op[i] >= 8'h80 && op[i] <= 8'h82)) op[i] = 8'h00;
      end else if (pick <= 5) begin
        if ($urandom_range(0, 2) == 0) op[i] = 8'($urandom_range(2, 6));
        else op[i] = {4'($urandom_range(1, 6)), 1'b0, 3'($urandom)};
      end else begin
        len[i] = 2;
        case (pick)
          6: op[i] = 8'h70;
          7: op[i] = 8'h80;
          8: op[i] = 8'h81;
          default: op[i] = 8'h82;
        endcase
      end
    end
    addr[0] = 0;
    for (int i = 0; i < n; i++) addr[i+1] = addr[i] + len[i];
    for (int i = 0; i < 256; i++) ins_mem[i] = 8'h01;
    for (int i = 0; i < n; i++) begin
      ins_mem[addr[i]] = op[i];
      if (len[i] == 2)
        ins_mem[addr[i]+1] = (op[i] == 8'h70) ? opnd[i] : 8'(addr[$urandom_range(i+1, n)]);
    end
  endtask

  int cyc;
  int base;

  initial begin
    rstN = 1'b0;
    startN = 1'b1;
    model_reset();
    for (int i = 0; i < 256; i++) ins_mem[i] = 8'h01;
    for (int i = 0; i < 4096; i++) data_mem[i] = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_ready", ready, 1'b1);
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_wren", DataMemWrEn, 1'b0);
    check_eq("rst_dout", ProcessorDataOut, 12'h000);
    check_eq("rst_daddr", dataMemAddr, 12'h000);
    check_eq("rst_iaddr", insMemAddr, 8'h00);
    rstN = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("idle_hold", ready, 1'b1);

    // LDIAC 5, END
    prep_mem();
    load_prog(256'({8'h70, 8'h05, 8'h01}), 3);
    exec_and_compare(cyc);
    check_eq("t1_ac", ProcessorDataOut, 12'h005);
    check_eq("t1_cyc", cyc, 7);
    repeat (4) @(negedge clk);
    check_eq("t1_done_held", done, 1'b1);
    check_eq("t1_not_ready", ready, 1'b0);

    // Build 0x800 via MUL/DEC/INC, store it at AR=3
    prep_mem();
    load_prog(256'({8'h70, 8'h03, 8'h10, 8'h70, 8'h80, 8'h12, 8'h70, 8'h10,
                    8'h52, 8'h06, 8'h05, 8'h04, 8'h01}), 13);
    base = wr_cnt;
    exec_and_compare(cyc);
    check_eq("t2_pulses", wr_cnt - base, 1);
    check_eq("t2_wr_addr", last_wr_addr, 12'h003);
    check_eq("t2_wr_data", last_wr_data, 12'h800);
    check_eq("t2_mem3", data_mem[3], 12'h800);
    check_eq("t2_cyc", cyc, 33);

    // data_mem[2]=9: LDAC then square it
    prep_mem();
    data_mem[2] = 12'd9;
    m_mem[2]    = 12'd9;
    load_prog(256'({8'h70, 8'h02, 8'h10, 8'h03, 8'h12, 8'h52, 8'h01}), 7);
    exec_and_compare(cyc);
    check_eq("t3_ac", ProcessorDataOut, 12'h051);
    check_eq("t3_addr", dataMemAddr, 12'h002);

    // Count-down loop of 4, then JMPZ skips LDIAC 0x55
    prep_mem();
    load_prog(256'({8'h70, 8'h04, 8'h11, 8'h21, 8'h06, 8'h11, 8'h81, 8'h03,
                    8'h80, 8'h0C, 8'h70, 8'h55, 8'h01}), 13);
    exec_and_compare(cyc);
    check_eq("t4_ac", ProcessorDataOut, 12'h000);
    check_eq("t4_cyc", cyc, 66);

    // 0xFF * 0xFFF wraps to 0xF01
    prep_mem();
    load_prog(256'({8'h02, 8'h06, 8'h11, 8'h70, 8'hFF, 8'h51, 8'h01}), 7);
    exec_and_compare(cyc);
    check_eq("t5_mul_wrap", ProcessorDataOut, 12'hF01);

    // SUB equal values -> 0 and Z=1 (JMPZ skips LDIAC 1)
    prep_mem();
    load_prog(256'({8'h70, 8'h33, 8'h13, 8'h43, 8'h80, 8'h08, 8'h70, 8'h01, 8'h01}), 9);
    exec_and_compare(cyc);
    check_eq("t5_sub_zero", ProcessorDataOut, 12'h000);

    for (int t = 0; t < 40; t++) begin
      prep_mem();
      gen_random();
      exec_and_compare(cyc);
    end

    // Long-running loop aborted by reset
    prep_mem();
    load_prog(256'({8'h70, 8'hFF, 8'h11, 8'h21, 8'h06, 8'h04, 8'h11, 8'h81,
                    8'h03, 8'h01}), 10);
    @(negedge clk); startN = 1'b0;
    @(negedge clk); startN = 1'b1;
    repeat (30) @(negedge clk);
    check_eq("mid_running", ready | done, 1'b0);
    rstN = 1'b0;
    #1;
    check_eq("abort_ready", ready, 1'b1);
    check_eq("abort_done", done, 1'b0);
    check_eq("abort_wren", DataMemWrEn, 1'b0);
    check_eq("abort_dout", ProcessorDataOut, 12'h000);
    check_eq("abort_daddr", dataMemAddr, 12'h000);
    check_eq("abort_iaddr", insMemAddr, 8'h00);
    model_reset();
    repeat (2) @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);

    prep_mem();
    load_prog(256'({8'h70, 8'h05, 8'h01}), 3);
    exec_and_compare(cyc);
    check_eq("restart_ac", ProcessorDataOut, 12'h005);
    check_eq("restart_cyc", cyc, 7);

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule
